// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the CPU run/halt/step controller.
// The state and halt-cause values are visible on the ports, so all users take them from here.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2,
    ST_STEP = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE   = 2'd0,
    CAUSE_EXT    = 2'd1,
    CAUSE_EBREAK = 2'd2,
    CAUSE_STEP   = 2'd3
  } cause_t;

  localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;

endpackage

// File: rtl/event_counter.sv
// Wrapping event counter with a synchronous clear that takes priority over increment.
// The output comes straight from the register, so an event shows up one cycle later.
module event_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (clr_i) begin
      r_cnt <= '0;
    end else if (inc_i) begin
      r_cnt <= r_cnt + WIDTH'(1);
    end
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/run_controller.sv
// Run/halt/single-step sequencer for the single-cycle RISC-V core.
// It gates the PC update and register writes, and counts active cycles and retired instructions.
module run_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH   = 32,
  parameter bit EBREAK_HALT = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 halt_req_i,
  input  logic                 step_req_i,
  input  logic                 resume_i,
  input  logic                 clr_cnt_i,
  input  logic [31:0]          instr_i,
  output logic                 pc_en_o,
  output logic                 commit_o,
  output logic [1:0]           state_o,
  output logic                 halted_o,
  output logic [1:0]           halt_cause_o,
  output logic [CNT_WIDTH-1:0] cycle_cnt_o,
  output logic [CNT_WIDTH-1:0] retire_cnt_o
);

  state_t r_state;
  state_t w_state_next;
  cause_t r_cause;
  cause_t w_cause_next;
  logic   r_skip;
  logic   w_skip_next;
  logic   w_ebreak_stop;
  logic   w_commit;
  logic   w_active;

  // After a resume, the skip flag lets the EBREAK that caused the halt retire once.
  assign w_ebreak_stop = EBREAK_HALT && (instr_i == EBREAK_INSTR) && !r_skip;

  assign w_commit = start_i &&
                    (((r_state == ST_RUN) && !halt_req_i && !w_ebreak_stop) ||
                     (r_state == ST_STEP));

  assign w_active = (r_state != ST_IDLE);

  always_comb begin
    w_state_next = r_state;
    w_cause_next = r_cause;
    w_skip_next  = r_skip && !w_commit;

    if (!start_i) begin
      w_state_next = ST_IDLE;
      w_cause_next = CAUSE_NONE;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          w_state_next = ST_RUN;
          w_cause_next = CAUSE_NONE;
        end
        ST_RUN: begin
          if (halt_req_i) begin
            w_state_next = ST_HALT;
            w_cause_next = CAUSE_EXT;
          end else if (w_ebreak_stop) begin
            w_state_next = ST_HALT;
            w_cause_next = CAUSE_EBREAK;
          end
        end
        ST_HALT: begin
          if (resume_i) begin
            w_state_next = ST_RUN;
            w_skip_next  = 1'b1;
          end else if (step_req_i) begin
            w_state_next = ST_STEP;
          end
        end
        ST_STEP: begin
          w_state_next = ST_HALT;
          w_cause_next = CAUSE_STEP;
        end
        default: begin
          w_state_next = ST_IDLE;
          w_cause_next = CAUSE_NONE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_cause <= CAUSE_NONE;
      r_skip  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cause <= w_cause_next;
      r_skip  <= w_skip_next;
    end
  end

  event_counter #(.WIDTH(CNT_WIDTH)) u_cycle_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (clr_cnt_i),
    .inc_i (w_active),
    .cnt_o (cycle_cnt_o)
  );

  event_counter #(.WIDTH(CNT_WIDTH)) u_retire_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (clr_cnt_i),
    .inc_i (w_commit),
    .cnt_o (retire_cnt_o)
  );

  assign pc_en_o      = w_commit;
  assign commit_o     = w_commit;
  assign state_o      = r_state;
  assign halted_o     = (r_state == ST_HALT);
  assign halt_cause_o = r_cause;

endmodule

// File: tb/tb_run_controller.sv
// Scoreboard bench for run_controller: directed scenarios followed by random pulses,
// compared against a cycle-level behavioural model of the run/halt/step rules.
module tb_run_controller;

  localparam int          CW    = 4;
  localparam logic [31:0] EBRK  = 32'h0010_0073;
  localparam logic [31:0] ADDI  = 32'h0010_0093;

  logic          clk;
  logic          rst;
  logic          start, halt_req, step_req, resume, clr_cnt;
  logic [31:0]   instr;
  logic          pc_en, commit, halted;
  logic [1:0]    state, cause;
  logic [CW-1:0] cyc_cnt, ret_cnt;

  run_controller #(.CNT_WIDTH(CW), .EBREAK_HALT(1'b1)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .halt_req_i   (halt_req),
    .step_req_i   (step_req),
    .resume_i     (resume),
    .clr_cnt_i    (clr_cnt),
    .instr_i      (instr),
    .pc_en_o      (pc_en),
    .commit_o     (commit),
    .state_o      (state),
    .halted_o     (halted),
    .halt_cause_o (cause),
    .cycle_cnt_o  (cyc_cnt),
    .retire_cnt_o (ret_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int id;
    int go;      // instruction allowed to commit
    int mode;    // 0 idle, 1 run, 2 halted, 3 stepping
    int why;     // halt reason code
    int cycles;
    int retired;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   txn      = 0;
  bit   stim_done = 1'b0;

  // Behavioural model: a mode number, a "just resumed" flag and two plain integers.
  int m_mode    = 0;
  int m_why     = 0;
  bit m_resumed = 1'b0;
  int m_cycles  = 0;
  int m_retired = 0;

  task automatic check(input string name, input int id, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s txn=%0d got=%0d expected=%0d", name, id, act, req);
  endtask

  // One clock period: drive inputs mid-cycle, predict outputs, advance the model.
  task automatic drive(input bit r, input bit s, input bit hr, input bit sr,
                       input bit rs, input bit clr, input logic [31:0] ins);
    exp_t e;
    bit   stops_here;
    @(negedge clk);
    rst = r; start = s; halt_req = hr; step_req = sr; resume = rs;
    clr_cnt = clr; instr = ins;
    txn++;
    e.id = txn;
    if (r) begin
      m_mode = 0; m_why = 0; m_resumed = 1'b0; m_cycles = 0; m_retired = 0;
      e.go = 0; e.mode = 0; e.why = 0; e.cycles = 0; e.retired = 0;
    end else begin
      stops_here = (ins == EBRK) && !m_resumed;
      e.go = s && ((m_mode == 1 && !hr && !stops_here) || m_mode == 3);
      e.mode = m_mode; e.why = m_why; e.cycles = m_cycles; e.retired = m_retired;
      if (clr) begin
        m_cycles = 0; m_retired = 0;
      end else begin
        m_cycles  = (m_cycles  + (m_mode != 0 ? 1 : 0)) % (1 << CW);
        m_retired = (m_retired + e.go) % (1 << CW);
      end
      if (e.go) m_resumed = 1'b0;
      if (!s) begin
        m_mode = 0; m_why = 0;
      end else if (m_mode == 0) begin
        m_mode = 1;
      end else if (m_mode == 1 && hr) begin
        m_mode = 2; m_why = 1;
      end else if (m_mode == 1 && stops_here) begin
        m_mode = 2; m_why = 2;
      end else if (m_mode == 2 && rs) begin
        m_mode = 1; m_resumed = 1'b1;
      end else if (m_mode == 2 && sr) begin
        m_mode = 3;
      end else if (m_mode == 3) begin
        m_mode = 2; m_why = 3;
      end
    end
    sb.push_back(e);
  endtask

  task automatic run_addi(input int n);
    for (int i = 0; i < n; i++) drive(0, 1, 0, 0, 0, 0, ADDI);
  endtask

  // Monitor: every cycle the DUT presents a response, compare it with the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("pc_en",      e.id, int'(pc_en),   e.go);
        check("commit",     e.id, int'(commit),  e.go);
        check("state",      e.id, int'(state),   e.mode);
        check("halted",     e.id, int'(halted),  (e.mode == 2) ? 1 : 0);
        check("halt_cause", e.id, int'(cause),   e.why);
        check("cycle_cnt",  e.id, int'(cyc_cnt), e.cycles);
        check("retire_cnt", e.id, int'(ret_cnt), e.retired);
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; halt_req = 1'b0; step_req = 1'b0;
    resume = 1'b0; clr_cnt = 1'b0; instr = ADDI;

    // Reset, then a plain ADDI run.
    drive(1, 0, 0, 0, 0, 0, ADDI);
    drive(1, 1, 0, 0, 0, 0, ADDI);
    drive(0, 1, 0, 0, 0, 0, ADDI);
    run_addi(10);

    // External halt mid-run, then three single steps.
    drive(0, 1, 0, 0, 0, 1, ADDI);
    run_addi(4);
    drive(0, 1, 1, 0, 0, 0, ADDI);
    run_addi(2);
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 0, 1, 0, 0, ADDI);
      run_addi(2);
    end

    // EBREAK halts, resume retires it once, the next EBREAK halts again.
    drive(0, 1, 0, 0, 1, 0, ADDI);
    run_addi(2);
    drive(0, 1, 0, 0, 0, 0, EBRK);
    drive(0, 1, 0, 0, 0, 0, EBRK);
    drive(0, 1, 0, 0, 1, 0, EBRK);
    drive(0, 1, 0, 0, 0, 0, EBRK);
    run_addi(2);
    drive(0, 1, 0, 0, 0, 0, EBRK);
    drive(0, 1, 0, 0, 0, 0, EBRK);

    // Resume beats step; halt request during STEP is ignored; step commits an EBREAK.
    drive(0, 1, 0, 1, 1, 0, ADDI);
    drive(0, 1, 1, 0, 0, 0, ADDI);
    drive(0, 1, 0, 1, 0, 0, ADDI);
    drive(0, 1, 1, 0, 0, 0, EBRK);
    drive(0, 1, 0, 0, 0, 0, ADDI);
    drive(0, 1, 0, 1, 0, 0, ADDI);
    drive(0, 1, 0, 0, 0, 0, EBRK);
    drive(0, 1, 0, 0, 0, 0, ADDI);

    // Back to RUN, then asynchronous reset between clock edges.
    drive(0, 1, 0, 0, 1, 0, ADDI);
    run_addi(3);
    drive(1, 1, 0, 0, 0, 0, ADDI);
    drive(0, 1, 0, 0, 0, 0, ADDI);

    // Long run wraps the narrow counters; clear while committing.
    run_addi(20);
    drive(0, 1, 0, 0, 0, 1, ADDI);
    run_addi(2);
    drive(0, 0, 0, 0, 0, 0, ADDI);
    drive(0, 0, 0, 0, 0, 0, ADDI);

    // Randomised pulses and instruction mix.
    for (int i = 0; i < 600; i++) begin
      bit       r, s, hr, sr, rs, clr;
      logic [31:0] ins;
      r   = ($urandom_range(99) < 1);
      s   = ($urandom_range(99) < 95);
      hr  = ($urandom_range(99) < 10);
      sr  = ($urandom_range(99) < 20);
      rs  = ($urandom_range(99) < 15);
      clr = ($urandom_range(99) < 4);
      ins = ($urandom_range(99) < 20) ? EBRK : ($urandom() & 32'hFFFF_FF7F);
      drive(r, s, hr, sr, rs, clr, ins);
    end

    stim_done = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #3;
    check("scoreboard_drained", txn, sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard bound so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout txn=%0d got=%0d expected=%0d", txn, int'(stim_done), 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/run_controller.md
Name: run_controller

Overview:
- Run/halt/single-step sequencer for the single-cycle RISC-V CPU.
- Decides each cycle whether the current instruction commits, using two gates:
  - pc_en_o gates the PC update.
  - commit_o is ANDed with Control RegWrite before it reaches Registers.
- Halts on an external request or on EBREAK, supports single-step and resume, and keeps cycle and retired-instruction counters for bring-up and verification.

Parameters:
- CNT_WIDTH, 32, width of cycle and retire counters.
- EBREAK_HALT, 1, 1 = EBREAK (32'h00100073) halts the core; 0 = EBREAK retires as a NOP.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- start_i  in  1  level; core may run while high.
- halt_req_i  in  1  single-cycle pulse, request halt.
- step_req_i  in  1  single-cycle pulse, execute one instruction from HALT.
- resume_i  in  1  single-cycle pulse, leave HALT and run.
- clr_cnt_i  in  1  synchronous clear of both counters.
- instr_i  in  32  instruction currently output by Instruction_Memory.
- pc_en_o  out  1  PC loads the next PC this cycle.
- commit_o  out  1  register write permitted this cycle; identical to pc_en_o.
- state_o  out  2  0 IDLE, 1 RUN, 2 HALT, 3 STEP.
- halted_o  out  1  state_o == HALT.
- halt_cause_o  out  2  0 none, 1 external, 2 ebreak, 3 step done.
- cycle_cnt_o  out  CNT_WIDTH  cycles spent outside IDLE.
- retire_cnt_o  out  CNT_WIDTH  instructions committed.

Behaviour:
- Reset (async, immediate):
  - state IDLE, halt_cause 0, skip flag 0, both counters 0.
  - pc_en_o = commit_o = 0 while rst_i is high and in the first cycle after release.
  - Reset mid-RUN or mid-STEP aborts with no commit in the reset cycle.
- Derived signal: ebreak_stop = EBREAK_HALT & (instr_i == 32'h00100073) & !skip.
- Combinational commit:
  - pc_en_o = commit_o = start_i & ((RUN & !halt_req_i & !ebreak_stop) | STEP).
  - STEP always commits, including EBREAK.
- Transitions (registered, priority top-down within each state):
  - IDLE:
    - start_i=1 -> RUN, cause 0.
  - RUN:
    - start_i=0 -> IDLE.
    - halt_req_i -> HALT, cause 1; current instruction not committed.
    - ebreak_stop -> HALT, cause 2; PC stays on the EBREAK.
    - otherwise stay in RUN.
  - HALT:
    - start_i=0 -> IDLE.
    - resume_i -> RUN, skip=1; resume wins over a simultaneous step_req_i.
    - step_req_i -> STEP.
    - otherwise hold.
  - STEP (exactly one cycle):
    - start_i=0 -> IDLE.
    - otherwise -> HALT, cause 3.
    - halt_req_i in STEP is ignored.
- skip flag:
  - Set on HALT->RUN.
  - Cleared on the first cycle in which commit_o=1 after that.
  - Lets a resume step past the EBREAK that caused the halt.
- Pulses arriving in states that do not consume them are dropped, not queued.
- halt_cause_o holds its value until the next entry into HALT; it returns to 0 on entry to IDLE.
- Counters:
  - cycle_cnt increments every cycle state != IDLE.
  - retire_cnt increments when commit_o=1.
  - Both wrap modulo 2^CNT_WIDTH with no saturation.
  - clr_cnt_i forces both to 0 that cycle, overriding any increment.
  - Counter outputs are registered, so a count is visible the cycle after its event.

Decomposition:
- Shared package cpu_ctrl_pkg:
  - state encoding (IDLE/RUN/HALT/STEP).
  - halt-cause encoding.
  - EBREAK_INSTR = 32'h00100073.
- Sub-module event_counter (param WIDTH; ports clk_i, rst_i, clr_i, inc_i, cnt_o), instantiated twice.
- FSM, skip flag and commit logic stay in run_controller.

Test Plan:
1. Reset then start_i=1 with ADDI stream, 10 cycles -> state_o=1 from cycle 1, pc_en_o=1 each cycle after, retire_cnt_o=10, cycle_cnt_o=10.
2. halt_req_i pulse at cycle 5 of RUN -> pc_en_o=0 that cycle, state_o=2, halt_cause_o=1, retire_cnt_o frozen at 4; three step_req_i pulses -> three single commits, cause=3, retire_cnt_o=7.
3. EBREAK in stream (EBREAK_HALT=1) -> halts with cause=2, PC not advanced; resume_i -> EBREAK commits once (retire +1), run continues; second EBREAK halts again.
4. resume_i and step_req_i in the same HALT cycle -> RUN, not STEP; halt_req_i during STEP -> ignored, ends HALT cause 3.
5. rst_i asserted asynchronously mid-RUN between clock edges -> pc_en_o/commit_o drop to 0 immediately, counters 0, state_o=0.
6. Counters preset near wrap with CNT_WIDTH=4 -> 15 wraps to 0; clr_cnt_i with commit_o=1 in the same cycle -> both counters read 0 next cycle.
